vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing source for the VGA path. Free-running column/row counters with an enable; produces the active-region sync flags and counts that `Sync_To_Count` and the game renderer consume on `i_HSync`/`i_VSync`. Also produces a one-cycle frame-start strobe and a frame counter for animation pacing, and can optionally produce porch-aligned, active-low sync pulses for the VGA connector. Sits between the pixel clock and the rest of the video pipeline.

## Interface
Parameters:
- `c_TOTAL_COLS`, 800: columns per line, including blanking.
- `c_TOTAL_ROWS`, 525: lines per frame, including blanking.
- `c_ACTIVE_COLS`, 640: visible columns.
- `c_ACTIVE_ROWS`, 480: visible rows.
- `c_H_FRONT_PORCH`, 16: columns between the end of active video and the start of the H sync pulse.
- `c_H_SYNC_WIDTH`, 96: H sync pulse width, in columns.
- `c_V_FRONT_PORCH`, 10: rows between the end of active video and the start of the V sync pulse.
- `c_V_SYNC_WIDTH`, 2: V sync pulse width, in rows.

Ports:
- `i_Clk` in 1: pixel clock (25 MHz); all logic is on the rising edge.
- `i_Rst_n` in 1: asynchronous, active-low reset.
- `i_Enable` in 1: when high, the counters advance one column per clock; when low, every output holds its value.
- `o_HSync` out 1: high while `o_Col_Count < c_ACTIVE_COLS`.
- `o_VSync` out 1: high while `o_Row_Count < c_ACTIVE_ROWS`.
- `o_Col_Count` out 10: current column.
- `o_Row_Count` out 10: current row.
- `o_Frame_Start` out 1: one-cycle strobe at (col 0, row 0).
- `o_Frame_Count` out 8: number of completed frames; wraps.
- `o_HSync_Porch` out 1: active-low H sync pulse for the connector.
- `o_VSync_Porch` out 1: active-low V sync pulse for the connector.

## Operation
- Column counter runs 0 to `c_TOTAL_COLS-1`, then wraps to 0. On the column wrap the row counter increments; rows run 0 to `c_TOTAL_ROWS-1`, then wrap to 0.
- Reset state is the last pixel of a frame:
  - col = `c_TOTAL_COLS-1`, row = `c_TOTAL_ROWS-1`.
  - `o_HSync` = 0, `o_VSync` = 0, `o_Frame_Start` = 0, `o_Frame_Count` = 0.
  - `o_HSync_Porch` = 1, `o_VSync_Porch` = 1.
  - Internal `r_First_Frame` = 1.
- First enabled edge after reset moves the position to (0,0) and asserts `o_Frame_Start`. `o_Frame_Count` does not increment on this edge; `r_First_Frame` clears.
- Every later wrap from (`c_TOTAL_COLS-1`, `c_TOTAL_ROWS-1`) to (0,0) asserts `o_Frame_Start` and increments `o_Frame_Count` modulo 256 (255 → 0).
- Per-axis region, derived from the count:
  - H: ACTIVE [0, 640), FRONT [640, 656), SYNC [656, 752), BACK [752, 800).
  - V: ACTIVE [0, 480), FRONT [480, 490), SYNC [490, 492), BACK [492, 525).
  - `o_*Sync_Porch` is low exactly in SYNC.
- `i_Enable` low: counters, flags, `o_Frame_Count` and porch pulses hold. `o_Frame_Start` goes to 0 on the next edge and stays 0 while disabled. Re-enabling continues from the held position.
- Reset asserted mid-frame: every output goes to its reset value immediately (asynchronously). Release takes effect on the first `i_Clk` edge after `i_Rst_n` goes high.
- Parameter constraints: `c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH ≤ c_TOTAL_COLS` (same rule for V), and `c_TOTAL_COLS`, `c_TOTAL_ROWS` ≤ 1024. Violating either is a configuration error; runtime behaviour is unspecified.

## Timing
- All outputs are registered. The flags, strobe and porch pulses are computed from the *next* count value, so they are cycle-aligned with `o_Col_Count`/`o_Row_Count`. There is no skew between any two outputs.
- Latency from `i_Enable` rising to the first count change: 1 clock.
- Line period is 800 enabled clocks; frame period is 420,000 enabled clocks.
- `o_Frame_Start` asserts once per frame and is never high for two consecutive cycles.

## Configuration
- Macro: `VGA_TIMING_PORCH_SYNC_EN`.
- Defined: the porch comparators and registers are compiled in, and `o_HSync_Porch`/`o_VSync_Porch` behave as described under Operation.
- Undefined: that logic is removed. The porch outputs are constant 1, including during reset. All other outputs are unchanged.

## Test plan
- Reset, then hold `i_Enable` = 1. After the first edge: col = 0, row = 0, `o_HSync` = 1, `o_VSync` = 1, `o_Frame_Start` = 1, `o_Frame_Count` = 0.
- Run 2 full frames (840,000 clocks). Exactly 2 further strobes, each at (0,0); `o_Frame_Count` = 2. `o_HSync` is high 640 of every 800 clocks; `o_VSync` is high for 480 of 525 lines.
- With the macro defined:
  - `o_HSync_Porch` is low for cols 656–751 inclusive.
  - `o_VSync_Porch` is low for rows 490–491.
  - Without the macro, both are stuck at 1 for the whole run.
- Drop `i_Enable` at col 100, row 5, for 50 clocks. All outputs hold and `o_Frame_Start` stays 0. On re-enable the next edge shows col 101.
- Force `o_Frame_Count` to 255 (run 256 frames, or preload via a bench `force`). The next frame wrap gives 0.
- Assert `i_Rst_n` low at col 300, row 200, mid-clock. Outputs go to their reset values before the next edge. After release, the first enabled edge reproduces the first scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, active flags, frame strobe/count; porch sync pulses under `VGA_TIMING_PORCH_SYNC_EN
module vga_timing_gen #(
  parameter int c_TOTAL_COLS    = 800,
  parameter int c_TOTAL_ROWS    = 525,
  parameter int c_ACTIVE_COLS   = 640,
  parameter int c_ACTIVE_ROWS   = 480,
  parameter int c_H_FRONT_PORCH = 16,
  parameter int c_H_SYNC_WIDTH  = 96,
  parameter int c_V_FRONT_PORCH = 10,
  parameter int c_V_SYNC_WIDTH  = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Enable,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic [7:0] o_Frame_Count,
  output logic       o_HSync_Porch,
  output logic       o_VSync_Porch
);
  localparam logic [9:0]  c_COL_LAST = 10'(c_TOTAL_COLS - 1);
  localparam logic [9:0]  c_ROW_LAST = 10'(c_TOTAL_ROWS - 1);
  localparam logic [10:0] c_H_ACT    = 11'(c_ACTIVE_COLS);
  localparam logic [10:0] c_V_ACT    = 11'(c_ACTIVE_ROWS);

  if (c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH > c_TOTAL_COLS ||
      c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH > c_TOTAL_ROWS ||
      c_TOTAL_COLS > 1024 || c_TOTAL_ROWS > 1024) begin : g_bad_cfg
    $error("vga_timing_gen: inconsistent timing parameters");
  end

  logic       r_First_Frame;
  logic       w_col_wrap;
  logic       w_frame_wrap;
  logic [9:0] w_col_next;
  logic [9:0] w_row_next;

  // next raster position; outputs register values derived from it so they stay aligned with the counts
  always_comb begin
    w_col_wrap   = o_Col_Count == c_COL_LAST;
    w_frame_wrap = w_col_wrap && (o_Row_Count == c_ROW_LAST);
    w_col_next   = w_col_wrap ? '0 : o_Col_Count + 10'd1;
    w_row_next   = !w_col_wrap ? o_Row_Count : (o_Row_Count == c_ROW_LAST) ? '0 : o_Row_Count + 10'd1;
  end

  // counters, active flags, frame strobe and frame count; reset parks on the last pixel of a frame
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Col_Count   <= c_COL_LAST;
      o_Row_Count   <= c_ROW_LAST;
      o_HSync       <= 1'b0;
      o_VSync       <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Frame_Count <= '0;
      r_First_Frame <= 1'b1;
    end else if (i_Enable) begin
      o_Col_Count   <= w_col_next;
      o_Row_Count   <= w_row_next;
      o_HSync       <= {1'b0, w_col_next} < c_H_ACT;
      o_VSync       <= {1'b0, w_row_next} < c_V_ACT;
      o_Frame_Start <= w_frame_wrap;
      o_Frame_Count <= (w_frame_wrap && !r_First_Frame) ? o_Frame_Count + 8'd1 : o_Frame_Count;
      r_First_Frame <= 1'b0;
    end else begin
      o_Frame_Start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_PORCH_SYNC_EN
  localparam logic [10:0] c_H_SYNC_START = 11'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
  localparam logic [10:0] c_H_SYNC_END   = 11'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH);
  localparam logic [10:0] c_V_SYNC_START = 11'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
  localparam logic [10:0] c_V_SYNC_END   = 11'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH);

  // active-low connector sync pulses, low only while the next position is inside the sync region
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_HSync_Porch <= 1'b1;
      o_VSync_Porch <= 1'b1;
    end else if (i_Enable) begin
      o_HSync_Porch <= !({1'b0, w_col_next} >= c_H_SYNC_START && {1'b0, w_col_next} < c_H_SYNC_END);
      o_VSync_Porch <= !({1'b0, w_row_next} >= c_V_SYNC_START && {1'b0, w_row_next} < c_V_SYNC_END);
    end
  end
`else
  assign o_HSync_Porch = 1'b1;
  assign o_VSync_Porch = 1'b1;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench on a reduced 20x10 raster
module tb_vga_timing_gen;
  // H: active 0-11, front 12-13, sync 14-16, back 17-19; V: active 0-5, front 6, sync 7-8, back 9
  localparam int TC = 20, TR = 10, AC = 12, AR = 6, HFP = 2, HSW = 3, VFP = 1, VSW = 2;
`ifdef VGA_TIMING_PORCH_SYNC_EN
  localparam bit PORCH = 1'b1;
`else
  localparam bit PORCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       hs, vs, fs, hp, vp;
  logic [9:0] col, row;
  logic [7:0] fc;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int exp_col, exp_row, exp_fc;
  bit exp_fs, exp_first, prev_fs;
  int n_bad = 0, n_fs = 0, n_hs = 0, n_vs = 0, n_hp_low = 0, n_vp_low = 0, n_dbl = 0;
  int hold_bad, k;

  vga_timing_gen #(
    .c_TOTAL_COLS(TC), .c_TOTAL_ROWS(TR), .c_ACTIVE_COLS(AC), .c_ACTIVE_ROWS(AR),
    .c_H_FRONT_PORCH(HFP), .c_H_SYNC_WIDTH(HSW), .c_V_FRONT_PORCH(VFP), .c_V_SYNC_WIDTH(VSW)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en),
    .o_HSync(hs), .o_VSync(vs), .o_Col_Count(col), .o_Row_Count(row),
    .o_Frame_Start(fs), .o_Frame_Count(fc), .o_HSync_Porch(hp), .o_VSync_Porch(vp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    exp_col = TC - 1;
    exp_row = TR - 1;
    exp_fc = 0;
    exp_fs = 1'b0;
    exp_first = 1'b1;
    prev_fs = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " col"}, 32'(col), 19);
    chk({tag, " row"}, 32'(row), 9);
    chk({tag, " hsync"}, 32'(hs), 0);
    chk({tag, " vsync"}, 32'(vs), 0);
    chk({tag, " fstart"}, 32'(fs), 0);
    chk({tag, " fcount"}, 32'(fc), 0);
    chk({tag, " hporch"}, 32'(hp), 1);
    chk({tag, " vporch"}, 32'(vp), 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bit wrap;
      bit e_hp, e_vp;
      tick;
      wrap = (exp_col == TC - 1) && (exp_row == TR - 1);
      if (exp_col == TC - 1) exp_row = (exp_row == TR - 1) ? 0 : exp_row + 1;
      exp_col = (exp_col == TC - 1) ? 0 : exp_col + 1;
      exp_fs = wrap;
      if (wrap && !exp_first) exp_fc = (exp_fc + 1) % 256;
      exp_first = 1'b0;
      e_hp = PORCH ? !(exp_col >= 14 && exp_col <= 16) : 1'b1;
      e_vp = PORCH ? !(exp_row >= 7 && exp_row <= 8) : 1'b1;
      if (col !== 10'(exp_col) || row !== 10'(exp_row) || fs !== exp_fs || fc !== 8'(exp_fc) ||
          hs !== (exp_col < 12) || vs !== (exp_row < 6) || hp !== e_hp || vp !== e_vp)
        n_bad++;
      if (fs === 1'b1) n_fs++;
      if (hs === 1'b1) n_hs++;
      if (vs === 1'b1) n_vs++;
      if (hp === 1'b0) n_hp_low++;
      if (vp === 1'b0) n_vp_low++;
      if (fs === 1'b1 && prev_fs) n_dbl++;
      prev_fs = (fs === 1'b1);
    end
  endtask

  initial begin
    model_reset;
    #2 rst_n = 1'b0;
    #10;
    check_reset("reset");

    rst_n = 1'b1;
    en = 1'b1;
    run(1);
    chk("first col", 32'(col), 0);
    chk("first row", 32'(row), 0);
    chk("first hsync", 32'(hs), 1);
    chk("first vsync", 32'(vs), 1);
    chk("first fstart", 32'(fs), 1);
    chk("first fcount", 32'(fc), 0);

    n_fs = 0; n_hs = 0; n_vs = 0; n_hp_low = 0; n_vp_low = 0; n_dbl = 0;
    run(400);
    chk("2frm strobes", 32'(n_fs), 2);
    chk("2frm fcount", 32'(fc), 2);
    chk("2frm col", 32'(col), 0);
    chk("2frm row", 32'(row), 0);
    chk("2frm hsync high", 32'(n_hs), 240);
    chk("2frm vsync high", 32'(n_vs), 240);
    chk("2frm hporch low", 32'(n_hp_low), PORCH ? 60 : 0);
    chk("2frm vporch low", 32'(n_vp_low), PORCH ? 80 : 0);
    chk("2frm double strobe", 32'(n_dbl), 0);
    chk("2frm model mismatches", 32'(n_bad), 0);

    en = 1'b0;
    tick;
    chk("dis fstart drop", 32'(fs), 0);
    chk("dis col", 32'(col), 0);
    chk("dis fcount", 32'(fc), 2);
    en = 1'b1;
    run(1);
    chk("reen col", 32'(col), 1);

    run(64);
    chk("pre-hold col", 32'(col), 5);
    chk("pre-hold row", 32'(row), 3);
    en = 1'b0;
    hold_bad = 0;
    repeat (50) begin
      tick;
      if (col !== 10'd5 || row !== 10'd3 || hs !== 1'b1 || vs !== 1'b1 || fs !== 1'b0 ||
          fc !== 8'd2 || hp !== 1'b1 || vp !== 1'b1)
        hold_bad++;
    end
    chk("hold mismatches", 32'(hold_bad), 0);
    en = 1'b1;
    run(1);
    chk("resume col", 32'(col), 6);
    chk("resume row", 32'(row), 3);

    k = 0;
    while (!(fs === 1'b1 && fc === 8'd255) && k < 60000) begin
      run(1);
      k++;
    end
    chk("fc reached 255", 32'(fc), 255);
    chk("fc255 col", 32'(col), 0);
    run(199);
    chk("pre-wrap col", 32'(col), 19);
    chk("pre-wrap row", 32'(row), 9);
    chk("pre-wrap fstart", 32'(fs), 0);
    run(1);
    chk("fc wrap count", 32'(fc), 0);
    chk("fc wrap fstart", 32'(fs), 1);

    run(87);
    chk("mid col", 32'(col), 7);
    chk("mid row", 32'(row), 4);
    #2 rst_n = 1'b0;
    #1;
    check_reset("async rst");
    model_reset;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst held col", 32'(col), 19);
    rst_n = 1'b1;
    run(1);
    chk("rerun col", 32'(col), 0);
    chk("rerun row", 32'(row), 0);
    chk("rerun hsync", 32'(hs), 1);
    chk("rerun vsync", 32'(vs), 1);
    chk("rerun fstart", 32'(fs), 1);
    chk("rerun fcount", 32'(fc), 0);
    run(200);
    chk("rerun fcount 1", 32'(fc), 1);
    chk("total model mismatches", 32'(n_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
